// File: rtl/tlul_mem_responder_pkg.sv
// Local constants and helpers for the TL-UL memory responder.
package tlul_mem_responder_pkg;

    localparam logic [15:0] LfsrSeed = 16'hACE1;

    function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

    // Fibonacci LFSR, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] lfsr);
        return {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL bus types and opcode enums shared across TL-UL endpoints, plus the
// response-entry layout and full-mask helper used by the memory responder.
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  size;
        logic [7:0]  source;
        logic [31:0] data;
        logic        error;
    } rsp_entry_t;

    // Byte lanes a PutFullData must carry for its size and low address bits.
    function automatic logic [3:0] full_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'd0:    return 4'b0001 << addr_lo;
            2'd1:    return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/tlul_mem_responder_if.sv
// TL-UL A/D channel bundle between a host and the memory responder.
interface tlul_mem_responder_if;
    import tlul_pkg::*;

    tl_h2d_t tl_i;
    tl_d2h_t tl_o;

    modport host   (output tl_i, input  tl_o);
    modport device (input  tl_i, output tl_o);
endinterface

// File: rtl/tlul_rsp_fifo.sv
// In-order response FIFO with saturating occupancy and wrapping pointers.
module tlul_rsp_fifo #(
    parameter int  Depth   = 2,
    parameter type entry_t = logic [7:0],
    parameter int  CntW    = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push,
    input  entry_t          wdata,
    input  logic            pop,
    output entry_t          rdata,
    output logic            full,
    output logic            empty,
    output logic [CntW-1:0] count
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    entry_t          storage [Depth];
    logic [PtrW-1:0] rptr;
    logic [PtrW-1:0] wptr;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = storage[rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            for (int i = 0; i < Depth; i++) storage[i] <= '0;
        end else begin
            if (do_push) begin
                storage[wptr] <= wdata;
                wptr          <= ptr_inc(wptr);
            end
            if (do_pop) rptr <= ptr_inc(rptr);
            if (do_push && !do_pop)      count <= count + CntW'(1);
            else if (do_pop && !do_push) count <= count - CntW'(1);
        end
    end

endmodule

// File: rtl/tlul_mem_responder.sv
// TL-UL device responder backed by a register memory, answering in order.
// Optional random A/D stall under macro TLUL_RESP_STALL_EN.
module tlul_mem_responder
    import tlul_pkg::*;
    import tlul_mem_responder_pkg::*;
#(
    parameter int          AddrWidth = 6,
    parameter logic [31:0] BaseAddr  = 32'h0000_0000,
    parameter int          RspDepth  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    tlul_mem_responder_if.device tl
);

    localparam int Words = 2 ** AddrWidth;
    localparam int CntW  = $clog2(RspDepth + 1);

    tl_h2d_t              req;
    tl_d2h_t              rsp;
    logic [31:0]          mem [Words];
    logic [AddrWidth-1:0] widx;
    logic                 is_get;
    logic                 is_write;
    logic                 err;
    logic                 stall;
    logic                 a_ready;
    logic                 d_valid;
    logic                 accept;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CntW-1:0]      fifo_count;
    rsp_entry_t           push_entry;
    rsp_entry_t           head;

    assign req  = tl.tl_i;
    assign widx = req.a_address[AddrWidth+1:2];

    always_comb begin
        is_get   = (req.a_opcode == Get);
        is_write = (req.a_opcode == PutFullData) || (req.a_opcode == PutPartialData);
        err      = 1'b0;
        if (!is_get && !is_write)                                      err = 1'b1;
        if (req.a_size > 2'd2)                                         err = 1'b1;
        if (addr_misaligned(req.a_size, req.a_address[1:0]))           err = 1'b1;
        if (req.a_address[31:AddrWidth+2] != BaseAddr[31:AddrWidth+2]) err = 1'b1;
        if ((req.a_opcode == PutFullData) &&
            (req.a_mask != full_mask(req.a_size, req.a_address[1:0]))) err = 1'b1;
        if (is_write && (req.a_mask == 4'b0000))                       err = 1'b1;
    end

`ifdef TLUL_RESP_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr <= LfsrSeed;
        else         lfsr <= lfsr_next(lfsr);
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Both handshakes derive from registered FIFO occupancy, never from d_ready.
    assign a_ready = !fifo_full && !stall;
    assign d_valid = !fifo_empty && !stall;
    assign accept  = req.a_valid && a_ready;
    assign pop     = d_valid && req.d_ready;

    always_comb begin
        push_entry        = '0;
        push_entry.opcode = is_get ? AccessAckData : AccessAck;
        push_entry.size   = req.a_size;
        push_entry.source = req.a_source;
        push_entry.error  = err;
        if (is_get) push_entry.data = err ? 32'hFFFF_FFFF : mem[widx];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Words; i++) mem[i] <= '0;
        end else if (accept && is_write && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (req.a_mask[b]) mem[widx][8*b +: 8] <= req.a_data[8*b +: 8];
            end
        end
    end

    tlul_rsp_fifo #(
        .Depth   (RspDepth),
        .entry_t (rsp_entry_t)
    ) u_rsp_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (accept),
        .wdata  (push_entry),
        .pop    (pop),
        .rdata  (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_comb begin
        rsp          = '0;
        rsp.d_valid  = d_valid;
        rsp.d_opcode = head.opcode;
        rsp.d_size   = head.size;
        rsp.d_source = head.source;
        rsp.d_data   = head.data;
        rsp.d_error  = head.error;
        rsp.a_ready  = a_ready;
    end

    assign tl.tl_o = rsp;

    count_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fifo_count <= CntW'(RspDepth));

endmodule
